// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared constants and state encoding for the NES pad responder.
// Button bit positions, host-side bit codes, and FSM states.
package nes_pad_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int A_IDX      = 0;
  localparam int B_IDX      = 1;
  localparam int SELECT_IDX = 2;
  localparam int START_IDX  = 3;
  localparam int UP_IDX     = 4;
  localparam int DOWN_IDX   = 5;
  localparam int LEFT_IDX   = 6;
  localparam int RIGHT_IDX  = 7;

  localparam int A_CODE      = 1;
  localparam int B_CODE      = 2;
  localparam int SELECT_CODE = 3;
  localparam int START_CODE  = 4;
  localparam int UP_CODE     = 5;
  localparam int DOWN_CODE   = 6;
  localparam int LEFT_CODE   = 7;
  localparam int RIGHT_CODE  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nes_pad_sync.sv
// nes_pad_sync: STAGES-deep synchronizer (STAGES >= 2) with rise/fall strobes.
// Ports: clk, reset (sync, high), d (async in), q (synced), rise, fall.
module nes_pad_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] ff;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff   <= '0;
      prev <= 1'b0;
    end else begin
      ff   <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1];
    end
  end

  assign q    = ff[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/nes_pad_emulator.sv
// nes_pad_emulator: 4021-style NES pad; latch snapshots buttons, pulses shift.
// Ports: clk, reset, latch_in, pulse_in, buttons[7:0] -> data_out, frame_done, bit_index, frame_error. Option: NES_PAD_DEBOUNCE_EN.
module nes_pad_emulator
  import nes_pad_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1500,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_in,
  input  logic       pulse_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic       frame_done,
  output logic [3:0] bit_index,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic latch_q, latch_rise, latch_fall;
  logic pulse_q, pulse_rise, pulse_fall;

  nes_pad_sync #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk  (clk),
    .reset(reset),
    .d    (latch_in),
    .q    (latch_q),
    .rise (latch_rise),
    .fall (latch_fall)
  );

  nes_pad_sync #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pulse_in),
    .q    (pulse_q),
    .rise (pulse_rise),
    .fall (pulse_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{latch_q, pulse_q, pulse_fall};

  logic [NUM_BUTTONS-1:0] btn_level;

`ifdef NES_PAD_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
    logic          b_q, b_r, b_f;
    logic          lvl;
    logic [DW-1:0] cnt;

    nes_pad_sync #(.STAGES(2)) u_bsync (
      .clk  (clk),
      .reset(reset),
      .d    (buttons[i]),
      .q    (b_q),
      .rise (b_r),
      .fall (b_f)
    );

    // Any edge restarts the stable window; the level follows only
    // after DEBOUNCE_CYCLES consecutive samples that differ from it.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (b_r | b_f) begin
        cnt <= '0;
      end else if (b_q == lvl) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= b_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign btn_level[i] = lvl;
  end
`else
  logic [NUM_BUTTONS-1:0] b_s1, b_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      b_s1 <= '0;
      b_s2 <= '0;
    end else begin
      b_s1 <= buttons;
      b_s2 <= b_s1;
    end
  end

  assign btn_level = b_s2;
`endif

  state_t                 state;
  logic [NUM_BUTTONS-1:0] shift_reg;
  logic [TW-1:0]          to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= 8'hFF;
      bit_index   <= 4'd8;
      to_cnt      <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      // Latch rise restarts the frame from any state and beats a
      // coincident pulse rise.
      if (latch_rise) begin
        state     <= LOAD;
        shift_reg <= ~btn_level;
        bit_index <= 4'd0;
        to_cnt    <= '0;
      end else begin
        case (state)
          LOAD: begin
            shift_reg <= ~btn_level;
            if (latch_fall) begin
              state  <= SHIFT;
              to_cnt <= '0;
            end
          end
          SHIFT: begin
            if (pulse_rise) begin
              shift_reg <= {1'b1, shift_reg[7:1]};
              to_cnt    <= '0;
              if (bit_index == 4'd7) begin
                bit_index  <= 4'd8;
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                bit_index <= bit_index + 4'd1;
              end
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              frame_error <= 1'b1;
              bit_index   <= 4'd8;
              shift_reg   <= 8'hFF;
              to_cnt      <= '0;
              state       <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Released (1) whenever no frame is being presented.
  assign data_out = (state == LOAD || state == SHIFT) ? shift_reg[0] : 1'b1;

endmodule
